// File: rtl/reorder_buffer.sv
// In-order retirement buffer between the CDB and the register file.
// Optional macro ROB_CDB_BYPASS_EN: let a not-yet-ready head commit straight from the CDB.
`ifndef PcLength
`define PcLength 31
`endif
`ifndef DataLength
`define DataLength 31
`endif

module reorder_buffer #(
    parameter int RobDepth      = 16,
    parameter int RobAddrLength = 3,
    parameter int RdLength      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 is_empty_from_decoder,
    input  logic [`PcLength:0]   pc_from_decoder,
    input  logic [RdLength:0]    rd_from_decoder,
    input  logic                 is_valid_from_cdb,
    input  logic [`PcLength:0]   pc_from_cdb,
    input  logic [`DataLength:0] data_from_cdb,
    input  logic                 is_mispredict_from_cdb,
    input  logic [`PcLength:0]   target_from_cdb,
    output logic                 is_full_to_decoder,
    output logic                 is_commit_to_rf,
    output logic                 is_exception_to_rf,
    output logic [RdLength:0]    rd_to_rf,
    output logic [`DataLength:0] data_to_rf,
    output logic [`PcLength:0]   pc_to_rf,
    output logic [`PcLength:0]   target_pc_to_fetch
);

    localparam logic [RobAddrLength+1:0] FullCount = (RobAddrLength+2)'(RobDepth);

    logic [RobAddrLength:0]   head_q, head_d, tail_q, tail_d;
    logic [RobAddrLength+1:0] count_q, count_d;

    logic                 busy_q   [RobDepth];
    logic                 busy_d   [RobDepth];
    logic                 ready_q  [RobDepth];
    logic                 ready_d  [RobDepth];
    logic                 misp_q   [RobDepth];
    logic                 misp_d   [RobDepth];
    logic [`PcLength:0]   pc_q     [RobDepth];
    logic [`PcLength:0]   pc_d     [RobDepth];
    logic [`PcLength:0]   target_q [RobDepth];
    logic [`PcLength:0]   target_d [RobDepth];
    logic [RdLength:0]    rd_q     [RobDepth];
    logic [RdLength:0]    rd_d     [RobDepth];
    logic [`DataLength:0] data_q   [RobDepth];
    logic [`DataLength:0] data_d   [RobDepth];

    logic                 is_commit_q, is_commit_d;
    logic                 is_exception_q, is_exception_d;
    logic [RdLength:0]    rd_out_q, rd_out_d;
    logic [`DataLength:0] data_out_q, data_out_d;
    logic [`PcLength:0]   pc_out_q, pc_out_d;
    logic [`PcLength:0]   target_out_q, target_out_d;

    logic                 alloc, commit, hd_misp;
    logic [`DataLength:0] hd_data;
    logic [`PcLength:0]   hd_target;

    assign is_full_to_decoder = (count_q == FullCount);

    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        busy_d         = busy_q;
        ready_d        = ready_q;
        misp_d         = misp_q;
        pc_d           = pc_q;
        target_d       = target_q;
        rd_d           = rd_q;
        data_d         = data_q;
        is_commit_d    = 1'b0;
        is_exception_d = 1'b0;
        rd_out_d       = rd_out_q;
        data_out_d     = data_out_q;
        pc_out_d       = pc_out_q;
        target_out_d   = target_out_q;
        alloc          = 1'b0;
        commit         = 1'b0;
        hd_misp        = misp_q[head_q];
        hd_data        = data_q[head_q];
        hd_target      = target_q[head_q];

        if (rdy) begin
            // Full is judged on the pre-edge count, so a full buffer rejects even while committing.
            alloc = !is_empty_from_decoder && !is_full_to_decoder;
            if (busy_q[head_q] && ready_q[head_q]) begin
                commit = 1'b1;
            end
`ifdef ROB_CDB_BYPASS_EN
            else if (busy_q[head_q] && is_valid_from_cdb && pc_q[head_q] == pc_from_cdb) begin
                commit    = 1'b1;
                hd_misp   = is_mispredict_from_cdb;
                hd_data   = data_from_cdb;
                hd_target = target_from_cdb;
            end
`endif

            for (int i = 0; i < RobDepth; i++) begin
                if (is_valid_from_cdb && busy_q[i] && pc_q[i] == pc_from_cdb) begin
                    ready_d[i]  = 1'b1;
                    data_d[i]   = data_from_cdb;
                    misp_d[i]   = is_mispredict_from_cdb;
                    target_d[i] = target_from_cdb;
                end
            end

            if (commit) begin
                is_commit_d    = 1'b1;
                rd_out_d       = rd_q[head_q];
                data_out_d     = hd_data;
                pc_out_d       = pc_q[head_q];
                busy_d[head_q] = 1'b0;
                head_d         = head_q + (RobAddrLength+1)'(1);
            end

            if (alloc) begin
                busy_d[tail_q]  = 1'b1;
                ready_d[tail_q] = 1'b0;
                pc_d[tail_q]    = pc_from_decoder;
                rd_d[tail_q]    = rd_from_decoder;
                tail_d          = tail_q + (RobAddrLength+1)'(1);
            end

            count_d = count_q + (RobAddrLength+2)'(alloc) - (RobAddrLength+2)'(commit);

            // A mispredicted head flushes everything, discarding this edge's allocation and CDB write.
            if (commit && hd_misp) begin
                is_exception_d = 1'b1;
                target_out_d   = hd_target;
                for (int i = 0; i < RobDepth; i++) begin
                    busy_d[i] = 1'b0;
                end
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            is_commit_q    <= 1'b0;
            is_exception_q <= 1'b0;
            rd_out_q       <= '0;
            data_out_q     <= '0;
            pc_out_q       <= '0;
            target_out_q   <= '0;
            for (int i = 0; i < RobDepth; i++) begin
                busy_q[i]   <= 1'b0;
                ready_q[i]  <= 1'b0;
                misp_q[i]   <= 1'b0;
                pc_q[i]     <= '0;
                target_q[i] <= '0;
                rd_q[i]     <= '0;
                data_q[i]   <= '0;
            end
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            is_commit_q    <= is_commit_d;
            is_exception_q <= is_exception_d;
            rd_out_q       <= rd_out_d;
            data_out_q     <= data_out_d;
            pc_out_q       <= pc_out_d;
            target_out_q   <= target_out_d;
            busy_q         <= busy_d;
            ready_q        <= ready_d;
            misp_q         <= misp_d;
            pc_q           <= pc_d;
            target_q       <= target_d;
            rd_q           <= rd_d;
            data_q         <= data_d;
        end
    end

    assign is_commit_to_rf    = is_commit_q;
    assign is_exception_to_rf = is_exception_q;
    assign rd_to_rf           = rd_out_q;
    assign data_to_rf         = data_out_q;
    assign pc_to_rf           = pc_out_q;
    assign target_pc_to_fetch = target_out_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomised and directed bench for reorder_buffer against a queue-based reference model.
`ifndef PcLength
`define PcLength 31
`endif
`ifndef DataLength
`define DataLength 31
`endif

module tb_reorder_buffer;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 rdy = 1'b1;
    logic                 dec_empty = 1'b1;
    logic [`PcLength:0]   dec_pc = '0;
    logic [4:0]           dec_rd = '0;
    logic                 cdb_v = 1'b0;
    logic [`PcLength:0]   cdb_pc = '0;
    logic [`DataLength:0] cdb_data = '0;
    logic                 cdb_misp = 1'b0;
    logic [`PcLength:0]   cdb_tgt = '0;
    logic                 is_full_to_decoder, is_commit_to_rf, is_exception_to_rf;
    logic [4:0]           rd_to_rf;
    logic [`DataLength:0] data_to_rf;
    logic [`PcLength:0]   pc_to_rf, target_pc_to_fetch;

    reorder_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .is_empty_from_decoder(dec_empty), .pc_from_decoder(dec_pc), .rd_from_decoder(dec_rd),
        .is_valid_from_cdb(cdb_v), .pc_from_cdb(cdb_pc), .data_from_cdb(cdb_data),
        .is_mispredict_from_cdb(cdb_misp), .target_from_cdb(cdb_tgt),
        .is_full_to_decoder(is_full_to_decoder), .is_commit_to_rf(is_commit_to_rf),
        .is_exception_to_rf(is_exception_to_rf), .rd_to_rf(rd_to_rf), .data_to_rf(data_to_rf),
        .pc_to_rf(pc_to_rf), .target_pc_to_fetch(target_pc_to_fetch)
    );

    always #5 clk = ~clk;

`ifdef ROB_CDB_BYPASS_EN
    localparam int BypassLat = 0;
`else
    localparam int BypassLat = 1;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        bit          done;
        logic [31:0] data;
        bit          misp;
        logic [31:0] tgt;
    } ent_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic [4:0]  rd;
        bit          exc;
        logic [31:0] tgt;
        int          c;
    } log_t;

    ent_t mq[$];
    log_t lg[$];
    bit          e_commit, e_exc;
    logic [4:0]  e_rd;
    logic [31:0] e_data, e_pc, e_tgt;
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        e_commit = 0; e_exc = 0; e_rd = '0; e_data = '0; e_pc = '0; e_tgt = '0;
    endtask

    // Reference behaviour: one rising edge applied to the in-order queue.
    task automatic model_step();
        bit   cm, full;
        ent_t h, t;
        if (!rst) begin
            model_clear();
            return;
        end
        e_commit = 0;
        e_exc = 0;
        if (!rdy) return;
        cm = 0;
        full = (mq.size() == 16);
        if (mq.size() > 0) begin
            h = mq[0];
            if (h.done) cm = 1;
            else if (BypassLat == 0 && cdb_v && h.pc == cdb_pc) begin
                cm = 1; h.data = cdb_data; h.misp = cdb_misp; h.tgt = cdb_tgt;
            end
        end
        for (int i = 0; i < mq.size(); i++) begin
            if (cdb_v && mq[i].pc == cdb_pc) begin
                t = mq[i];
                t.done = 1; t.data = cdb_data; t.misp = cdb_misp; t.tgt = cdb_tgt;
                mq[i] = t;
            end
        end
        if (cm) begin
            void'(mq.pop_front());
            e_commit = 1; e_rd = h.rd; e_data = h.data; e_pc = h.pc;
            if (h.misp) begin
                e_exc = 1; e_tgt = h.tgt;
                mq.delete();
                return;
            end
        end
        if (!dec_empty && !full) begin
            t.pc = dec_pc; t.rd = dec_rd; t.done = 0; t.data = '0; t.misp = 0; t.tgt = '0;
            mq.push_back(t);
        end
    endtask

    task automatic step();
        log_t l;
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        chk("commit", is_commit_to_rf, e_commit);
        chk("exception", is_exception_to_rf, e_exc);
        chk("rd", rd_to_rf, e_rd);
        chk("data", data_to_rf, e_data);
        chk("pc", pc_to_rf, e_pc);
        chk("target", target_pc_to_fetch, e_tgt);
        chk("full", is_full_to_decoder, (mq.size() == 16));
        if (is_commit_to_rf) begin
            l.pc = pc_to_rf; l.data = data_to_rf; l.rd = rd_to_rf;
            l.exc = is_exception_to_rf; l.tgt = target_pc_to_fetch; l.c = cyc;
            lg.push_back(l);
        end
    endtask

    task automatic idle(input int n);
        dec_empty = 1; cdb_v = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic issue(input logic [31:0] pc, input logic [4:0] rd);
        dec_empty = 0; dec_pc = pc; dec_rd = rd; cdb_v = 0;
        step();
        dec_empty = 1;
    endtask

    task automatic cdb(input logic [31:0] pc, input logic [31:0] d, input bit m, input logic [31:0] tg);
        cdb_v = 1; cdb_pc = pc; cdb_data = d; cdb_misp = m; cdb_tgt = tg;
        step();
        cdb_v = 0; cdb_misp = 0;
    endtask

    // Asynchronous assertion checked mid-cycle, traffic driven while held, synchronous release.
    task automatic do_reset();
        rst = 0;
        #1;
        model_clear();
        chk("rst_async_commit", is_commit_to_rf, 0);
        chk("rst_async_pc", pc_to_rf, 0);
        chk("rst_async_full", is_full_to_decoder, 0);
        dec_empty = 0; dec_pc = 32'h44; cdb_v = 1; cdb_pc = 32'h44; rdy = 1;
        step();
        step();
        @(negedge clk);
        rst = 1;
        dec_empty = 1; cdb_v = 0;
        lg.delete();
    endtask

    initial begin
        int c0;
        logic [31:0] next_pc;
        #2;
        // Reset, then in-order retirement of out-of-order results.
        do_reset();
        issue(32'h10, 5'd1);
        issue(32'h14, 5'd2);
        issue(32'h18, 5'd3);
        cdb(32'h18, 32'd3, 0, '0);
        cdb(32'h14, 32'd2, 0, '0);
        cdb(32'h10, 32'd1, 0, '0);
        idle(4);
        chk("inorder_count", lg.size(), 3);
        if (lg.size() == 3) begin
            chk("inorder_pc0", lg[0].pc, 32'h10);
            chk("inorder_d0", lg[0].data, 1);
            chk("inorder_rd0", lg[0].rd, 1);
            chk("inorder_pc1", lg[1].pc, 32'h14);
            chk("inorder_d1", lg[1].data, 2);
            chk("inorder_pc2", lg[2].pc, 32'h18);
            chk("inorder_rd2", lg[2].rd, 3);
            chk("inorder_b2b", lg[2].c - lg[0].c, 2);
        end

        // Fill to 16, hold a 17th issue, retire the head, expect the 17th to land.
        do_reset();
        for (int i = 0; i < 16; i++) issue(32'h200 + 32'(4 * i), 5'(i));
        chk("full_set", is_full_to_decoder, 1);
        dec_empty = 0; dec_pc = 32'h400; dec_rd = 5'd17;
        step();
        chk("full_reject", is_full_to_decoder, 1);
        cdb_v = 1; cdb_pc = 32'h200; cdb_data = 32'hAA; cdb_misp = 0;
        step();
        cdb_v = 0;
        step();
        step();
        dec_empty = 1;
        chk("full_refill", is_full_to_decoder, 1);
        for (int i = 1; i < 16; i++) cdb(32'h200 + 32'(4 * i), 32'(i), 0, '0);
        cdb(32'h400, 32'h55, 0, '0);
        idle(3);
        chk("full_total", lg.size(), 17);
        if (lg.size() == 17) chk("full_last_pc", lg[16].pc, 32'h400);

        // Mispredict at head flushes the buffer.
        do_reset();
        issue(32'h20, 5'd4);
        issue(32'h24, 5'd5);
        issue(32'h28, 5'd6);
        cdb(32'h20, 32'h9, 1, 32'h100);
        dec_empty = 0; dec_pc = 32'h2C; dec_rd = 5'd7;
        step();
        dec_empty = 1;
        idle(1);
        cdb(32'h24, 32'h1, 0, '0);
        idle(3);
        chk("misp_count", lg.size(), 1);
        if (lg.size() == 1) begin
            chk("misp_pc", lg[0].pc, 32'h20);
            chk("misp_exc", lg[0].exc, 1);
            chk("misp_tgt", lg[0].tgt, 32'h100);
        end
        chk("misp_not_full", is_full_to_decoder, 0);

        // Commit latency from the CDB result.
        do_reset();
        issue(32'h30, 5'd8);
        idle(1);
        cdb(32'h30, 32'd7, 0, '0);
        c0 = cyc;
        idle(3);
        chk("byp_count", lg.size(), 1);
        if (lg.size() == 1) begin
            chk("byp_latency", lg[0].c - c0, BypassLat);
            chk("byp_data", lg[0].data, 7);
        end

        // Random traffic with stalls, wrap-around, rare mispredicts and a mid-run reset.
        do_reset();
        next_pc = 32'h1000;
        for (int n = 0; n < 900; n++) begin
            if (n == 450) do_reset();
            rdy = ($urandom_range(0, 3) != 0);
            dec_empty = ($urandom_range(0, 2) == 0);
            dec_pc = next_pc;
            dec_rd = 5'($urandom_range(0, 31));
            next_pc = next_pc + 4;
            cdb_v = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
            cdb_pc = (mq.size() > 0) ? mq[$urandom_range(0, mq.size() - 1)].pc : 32'h0;
            if ($urandom_range(0, 7) == 0) cdb_pc = 32'hFFFF_0000 | 32'($urandom_range(0, 255));
            cdb_data = $urandom;
            cdb_misp = ($urandom_range(0, 23) == 0);
            cdb_tgt = $urandom;
            step();
            if (!rdy) chk("stall_strobe", is_commit_to_rf | is_exception_to_rf, 0);
        end
        rdy = 1;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement stage between the execution units' common data bus (CDB) and the register file. It allocates an entry per issued instruction, tagged by its pc, and collects results from the CDB. It retires the oldest completed entry each cycle as a registered commit (rd, data, pc) to the register file. On a mispredicted control-flow result reaching the head, it raises the exception/flush strobe and a redirect target.

## Interface
- RobDepth, 16: number of entries; power of two.
- RobAddrLength, 3: entry index width minus one (log2(RobDepth)-1).
- RdLength, 4: destination register index width minus one.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset: asynchronous, active-low. Asserting low clears all state immediately; release is synchronous to clk.
- rdy  in  1  global enable; low = stall, state held.
- is_empty_from_decoder  in  1  high = no instruction issued this cycle.
- pc_from_decoder  in  `PcLength+1  tag (pc) of issued instruction.
- rd_from_decoder  in  RdLength+1  destination register (0 = none).
- is_valid_from_cdb  in  1  CDB carries a result this cycle.
- pc_from_cdb  in  `PcLength+1  tag of producing instruction.
- data_from_cdb  in  `DataLength+1  result value.
- is_mispredict_from_cdb  in  1  result is a mispredicted branch/jump.
- target_from_cdb  in  `PcLength+1  correct next pc when mispredicted.
- is_full_to_decoder  out  1  combinational, count == RobDepth.
- is_commit_to_rf  out  1  one-cycle commit strobe.
- is_exception_to_rf  out  1  one-cycle flush strobe, coincident with the mispredicted commit.
- rd_to_rf  out  RdLength+1  committed rd.
- data_to_rf  out  `DataLength+1  committed value.
- pc_to_rf  out  `PcLength+1  committed tag.
- target_pc_to_fetch  out  `PcLength+1  redirect pc, valid while is_exception_to_rf is high.

## Operation
- Circular buffer. Head and tail indices are RobAddrLength+1 bits and wrap modulo RobDepth. Count is RobAddrLength+2 bits, range 0..RobDepth.
- Per entry: busy, ready, pc, rd, data, mispredict, target.
- Allocate: when !is_empty_from_decoder && !is_full_to_decoder, write the entry at tail (busy=1, ready=0) and advance tail. When full, the request is ignored; the decoder holds and retries.
- CDB write: on is_valid_from_cdb, every busy entry with pc == pc_from_cdb gets ready=1 and latches data, mispredict and target. A non-matching tag is ignored.
- Commit: when the head entry is busy && ready, the block registers is_commit_to_rf=1, rd, data and pc, clears busy and advances head. At most one commit per cycle. With no commit, both strobes register to 0; rd, data, pc and target hold.
- Mispredict at head: the commit proceeds as above with is_exception_to_rf=1 and target_pc_to_fetch=target. On the same edge all entries clear, head=tail=0 and count=0. A decoder allocation or CDB write presented on that edge is discarded.
- Count: next = count + alloc − commit. Simultaneous alloc and commit keep count unchanged. Full is evaluated from the pre-edge count, so a full buffer rejects allocation even while committing.
- rdy low: entries, indices and data outputs hold; both strobes register to 0.
- Reset (rst low): all entries non-busy, head=tail=count=0, every output 0.

## Timing
- Allocation visible one edge after issue. The earliest CDB write for a tag is the cycle after allocation.
- Without bypass: CDB write at edge N sets ready; commit outputs appear after edge N+1.
- Commit strobes are single-cycle pulses. Back-to-back ready entries give one commit per cycle.
- Flush: after the flagging edge the buffer is empty and is_full_to_decoder=0. Allocation is accepted again on the next edge.
- Reset mid-operation: outputs drop to 0 asynchronously, with no partial commit.

## Configuration
- ROB_CDB_BYPASS_EN defined: if the head is busy, not ready, and matches pc_from_cdb with is_valid_from_cdb, it commits on that same edge using the CDB data, mispredict and target. This includes the exception/flush case. Commit latency from the CDB result is 1 edge.
- Undefined: the head must be ready before the edge, so commit latency from the CDB result is 2 edges.

## Test plan
- Reset: hold rst low, drive traffic → all outputs 0, is_full_to_decoder=0; after release, one allocation gives count 1.
- In-order retire: allocate pc 0x10/rd 1, 0x14/rd 2, 0x18/rd 3; CDB answers 0x18, 0x14, 0x10 (data 3, 2, 1) → commits in order 0x10/1/1, 0x14/2/2, 0x18/3/3 on consecutive cycles.
- Full: allocate 16 entries with no CDB activity → is_full_to_decoder=1 and a 17th issue is ignored. Then complete the head while a 17th issue is held → the allocation is accepted on the edge after the commit.
- Mispredict: entries 0x20, 0x24, 0x28; CDB 0x20 with mispredict=1, target 0x100 → one cycle with is_commit_to_rf=1, is_exception_to_rf=1, pc_to_rf=0x20, target_pc_to_fetch=0x100; afterwards count=0, and later CDB 0x24 produces no commit.
- Wrap and stall: run 40 alloc/commit pairs with rdy toggling → no lost or duplicated commits; strobes stay 0 while rdy is low.
- Bypass: head 0x30 not ready, CDB 0x30 data 7 → commit after 1 edge with ROB_CDB_BYPASS_EN defined, after 2 edges without it.
